sar_track_ctrl: RTL and testbench
=================================

# sar_track_ctrl

Parametrised successive-approximation controller for the FMDLL delay-line code. It runs a binary search of `WIDTH` bits on the phase-comparator output, waiting a programmable settle interval before each decision, and reports completion with a start/done handshake. After convergence it optionally switches to ±1 bang-bang tracking to follow slow drift. It sits between the phase detector (`comp`) and the delay-line DAC/decoder (`code`).

## Interface
Parameters:
- `WIDTH`, 10, code width in bits; must be ≥ 2.
- `SETTLE`, 4, cycles per decision; must be ≥ 1.

Ports (the clock is `clk4`; reset is `rst`):
- `clk4`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a new search; sampled on the rising edge.
- `comp`, input, 1: phase comparator; 1 = lead (keep/increase), 0 = lag (clear/decrease).
- `code`, output, `WIDTH`: delay-line code; registered.
- `busy`, output, 1: search in progress; registered.
- `done`, output, 1: one-cycle pulse on search completion; registered.
- `locked`, output, 1: high from completion until the next accepted start or reset; registered.
- `sample`, output, 1: combinational; high in every cycle in which `comp` is consumed.

## Operation
- States: IDLE, SEARCH, LOCK.
- Internal registers: bit index `idx` (`$clog2(WIDTH)` bits) and settle counter `cnt` (`$clog2(SETTLE+1)` bits).
- Reset values:
  - `code` = 1 << (WIDTH-1) (mid-scale).
  - `busy` = `done` = `locked` = 0.
  - state = IDLE, `idx` = WIDTH-1, `cnt` = 0.
- Start acceptance:
  - `start` is accepted in IDLE or LOCK.
  - On acceptance: `code` = 1 << (WIDTH-1), `idx` = WIDTH-1, `cnt` = SETTLE-1, `busy` = 1, `locked` = 0, state = SEARCH.
  - `start` is ignored in SEARCH.
- SEARCH:
  - While `cnt` ≠ 0, decrement `cnt`; `sample` = 0.
  - When `cnt` = 0, `sample` = 1 and a decision is made:
    - If `comp` = 0, clear `code[idx]`.
    - If `idx` ≠ 0, also set `code[idx-1]`, decrement `idx`, and reload `cnt` = SETTLE-1.
    - If `idx` = 0, go to LOCK, set `busy` = 0, `done` = 1 for one cycle, `locked` = 1, and `cnt` = SETTLE-1.
- LOCK:
  - `code` holds unless tracking is compiled in (see Configuration).
  - A new `start` restarts the search.
- Bits below `idx` are always 0 during SEARCH.
- `done` and `locked` are never both asserted with `busy`.

## Timing
- Start accepted at edge E0; `code` shows mid-scale after E0.
- Decision k (k = 1..WIDTH) updates `code` at edge E(k·SETTLE).
- `busy` falls and `done` rises at edge E(WIDTH·SETTLE); the final `code` is valid in that same cycle.
  - Default: WIDTH = 10, SETTLE = 4 gives E40.
- SETTLE = 1: a decision on every edge; `sample` stays high throughout SEARCH.
- `rst` mid-search aborts immediately (asynchronous) to the reset values; no `done` pulse is produced.
- `start` in the same cycle as a LOCK tracking step: the restart wins and the tracking step is discarded.

## Configuration
- Macro `SAR_TRACK_EN`.
- Defined:
  - In LOCK, `cnt` counts down as in SEARCH.
  - When `cnt` = 0, `sample` = 1: `comp` = 1 gives `code` + 1, saturating at all-ones; `comp` = 0 gives `code` − 1, saturating at 0. `cnt` is then reloaded to SETTLE-1.
  - `locked` stays high during tracking.
- Undefined: in LOCK, `code` is frozen, `comp` is ignored, and `sample` = 0.

## Test plan
Comparator model for all tests: `comp` = (`code` ≤ target).
- Search: WIDTH = 10, SETTLE = 4, target 0x2A7, `start` pulse → `busy` high E0..E39, `done` pulse after E40, `code` = 0x2A7, `locked` = 1, exactly 10 `sample` cycles.
- Extremes: target 0x000 → `code` = 0x000; target 0x3FF → `code` = 0x3FF; both complete at E40.
- Tracking with `SAR_TRACK_EN`:
  - After lock at 0x3FF with `comp` held 1 → `code` stays 0x3FF (saturation).
  - Target then changed to 0x3FD → `code` reaches 0x3FD after 2 tracking steps (8 cycles), then alternates between 0x3FD and 0x3FE.
- Tracking without `SAR_TRACK_EN`: the same stimulus leaves `code` = 0x3FF and `sample` = 0 in LOCK.
- Reset and busy handling:
  - `rst` pulse at E17 → `code` = 0x200, `busy` = 0, no `done`.
  - `start` re-asserted at E5 → ignored; completion still at E40.
- Alternate parameters: WIDTH = 6, SETTLE = 1, target 0x15 → `done` after E6, `code` = 0x15; a `start` in LOCK restarts from 0x20 with `locked` = 0.

Source files
------------

// File: rtl/sar_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sar_track_ctrl
//  Purpose  : Successive-approximation search of the FMDLL delay-line code,
//             with optional +/-1 bang-bang tracking after lock
//             (enabled by defining SAR_TRACK_EN).
//  Revision : 1.0  initial release
// ============================================================================
module sar_track_ctrl #(
   parameter int WIDTH  = 10,
   parameter int SETTLE = 4
) (
   input  logic             clk4,
   input  logic             rst,
   input  logic             start,
   input  logic             comp,
   output logic [WIDTH-1:0] code,
   output logic             busy,
   output logic             done,
   output logic             locked,
   output logic             sample
);

   localparam int IW = $clog2(WIDTH);
   localparam int CW = $clog2(SETTLE + 1);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_search = 2'd1;
   localparam logic [1:0] c_st_lock   = 2'd2;

   localparam logic [WIDTH-1:0] c_mid        = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [IW-1:0]    c_idx_top    = IW'(WIDTH - 1);
   localparam logic [CW-1:0]    c_cnt_reload = CW'(SETTLE - 1);

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] code_q,   code_d;
   logic [IW-1:0]    idx_q,    idx_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic             locked_q, locked_d;
   logic             sample_w;

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      locked_d = locked_q;
      sample_w = 1'b0;

      case (state_q)
         c_st_search: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               sample_w = 1'b1;
               if (!comp) begin
                  code_d[idx_q] = 1'b0;
               end
               if (idx_q != '0) begin
                  code_d[idx_q - IW'(1)] = 1'b1;
                  idx_d                  = idx_q - IW'(1);
                  cnt_d                  = c_cnt_reload;
               end else begin
                  state_d  = c_st_lock;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  locked_d = 1'b1;
                  cnt_d    = c_cnt_reload;
               end
            end
         end

         c_st_idle, c_st_lock: begin
            if (start) begin
               // Restart takes priority over any tracking step due this cycle
               state_d  = c_st_search;
               code_d   = c_mid;
               idx_d    = c_idx_top;
               cnt_d    = c_cnt_reload;
               busy_d   = 1'b1;
               locked_d = 1'b0;
            end
`ifdef SAR_TRACK_EN
            else if (state_q == c_st_lock) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CW'(1);
               end else begin
                  sample_w = 1'b1;
                  cnt_d    = c_cnt_reload;
                  if (comp) begin
                     if (!(&code_q)) code_d = code_q + WIDTH'(1);
                  end else begin
                     if (|code_q) code_d = code_q - WIDTH'(1);
                  end
               end
            end
`endif
         end

         default: begin
            state_d = c_st_idle;
         end
      endcase
   end

   always_ff @(posedge clk4 or posedge rst) begin
      if (rst) begin
         state_q  <= c_st_idle;
         code_q   <= c_mid;
         idx_q    <= c_idx_top;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         locked_q <= locked_d;
      end
   end

   assign code   = code_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign locked = locked_q;
   assign sample = sample_w;

endmodule
`default_nettype wire

// File: tb/tb_sar_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sar_track_ctrl
//  Purpose  : Directed self-checking bench for sar_track_ctrl, two instances
//             (10-bit/settle 4 and 6-bit/settle 1), comparator = code <= target.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sar_track_ctrl;

   logic       clk4;
   logic       rst;
   logic       start_a, start_b;
   logic       comp_a, comp_b;
   logic [9:0] code_a,  tgt_a;
   logic [5:0] code_b,  tgt_b;
   logic       busy_a, done_a, locked_a, sample_a;
   logic       busy_b, done_b, locked_b, sample_b;

   int n_chk = 0;
   int n_err = 0;

   sar_track_ctrl #(.WIDTH(10), .SETTLE(4)) dut_a (
      .clk4(clk4), .rst(rst), .start(start_a), .comp(comp_a),
      .code(code_a), .busy(busy_a), .done(done_a), .locked(locked_a),
      .sample(sample_a)
   );

   sar_track_ctrl #(.WIDTH(6), .SETTLE(1)) dut_b (
      .clk4(clk4), .rst(rst), .start(start_b), .comp(comp_b),
      .code(code_b), .busy(busy_b), .done(done_b), .locked(locked_b),
      .sample(sample_b)
   );

   assign comp_a = (code_a <= tgt_a);
   assign comp_b = (code_b <= tgt_b);

   initial clk4 = 1'b0;
   always #5 clk4 = ~clk4;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk4);
      #1;
   endtask

   // Full search on dut_a; optional extra start pulse at edge E<restart_at>.
   task automatic run_a(input logic [9:0] t, input int restart_at, input string tag);
      int n_busy, n_samp, n_done;
      tgt_a   = t;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk({tag, "_e0_code"}, code_a, 32'h200);
      chk({tag, "_e0_locked"}, locked_a, 0);
      n_busy = busy_a;
      n_samp = sample_a;
      n_done = done_a;
      for (int k = 1; k < 40; k++) begin
         if (k == restart_at) start_a = 1'b1;
         tick();
         start_a = 1'b0;
         n_busy += busy_a;
         n_samp += sample_a;
         n_done += done_a;
      end
      chk({tag, "_busy_cycles"}, n_busy, 40);
      chk({tag, "_sample_cycles"}, n_samp, 10);
      chk({tag, "_early_done"}, n_done, 0);
      tick();
      chk({tag, "_e40_code"}, code_a, t);
      chk({tag, "_e40_busy"}, busy_a, 0);
      chk({tag, "_e40_done"}, done_a, 1);
      chk({tag, "_e40_locked"}, locked_a, 1);
      tick();
      chk({tag, "_e41_done"}, done_a, 0);
   endtask

   initial begin
      int n_samp, n_done, n_busy;
      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      tgt_a   = 10'h0;
      tgt_b   = 6'h0;
      #12;
      chk("rst_code", code_a, 32'h200);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_locked", locked_a, 0);
      chk("rst_sample", sample_a, 0);
      chk("rst_code_b", code_b, 32'h20);
      rst = 1'b0;
      tick();

      run_a(10'h2A7, -1, "srch");
      run_a(10'h000, -1, "min");
      run_a(10'h2A7,  5, "restart_busy");
      run_a(10'h3FF, -1, "max");

      // Now after E41 in LOCK at 0x3FF; hold target at full scale to E48.
      n_samp = 0;
      for (int k = 42; k <= 48; k++) begin
         tick();
         n_samp += sample_a;
      end
      chk("sat_code", code_a, 32'h3FF);
`ifdef SAR_TRACK_EN
      chk("sat_samples", n_samp, 2);
`else
      chk("sat_samples", n_samp, 0);
`endif
      tgt_a  = 10'h3FD;
      n_samp = 0;
      for (int k = 49; k <= 56; k++) begin
         tick();
         n_samp += sample_a;
      end
`ifdef SAR_TRACK_EN
      chk("trk_e56_code", code_a, 32'h3FD);
`else
      chk("trk_e56_code", code_a, 32'h3FF);
`endif
      for (int k = 57; k <= 60; k++) begin
         tick();
         n_samp += sample_a;
      end
`ifdef SAR_TRACK_EN
      chk("trk_e60_code", code_a, 32'h3FE);
`else
      chk("trk_e60_code", code_a, 32'h3FF);
`endif
      for (int k = 61; k <= 64; k++) begin
         tick();
         n_samp += sample_a;
      end
`ifdef SAR_TRACK_EN
      chk("trk_e64_code", code_a, 32'h3FD);
      chk("trk_samples", n_samp, 4);
`else
      chk("trk_e64_code", code_a, 32'h3FF);
      chk("trk_samples", n_samp, 0);
`endif
      chk("trk_locked", locked_a, 1);
      chk("trk_busy", busy_a, 0);

      // Asynchronous reset in the middle of a search.
      tgt_a   = 10'h2A7;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int k = 1; k <= 17; k++) tick();
      chk("mid_busy", busy_a, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_code", code_a, 32'h200);
      chk("arst_busy", busy_a, 0);
      chk("arst_locked", locked_a, 0);
      rst = 1'b0;
      n_done = 0;
      n_busy = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         n_done += done_a;
         n_busy += busy_a;
      end
      chk("arst_no_done", n_done, 0);
      chk("arst_no_busy", n_busy, 0);
      chk("arst_idle_code", code_a, 32'h200);

      // dut_b: WIDTH 6, SETTLE 1 -> one decision per edge.
      tgt_b   = 6'h15;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_e0_code", code_b, 32'h20);
      n_samp = sample_b;
      n_done = done_b;
      for (int k = 1; k < 6; k++) begin
         tick();
         n_samp += sample_b;
         n_done += done_b;
      end
      chk("b_samples", n_samp, 6);
      chk("b_early_done", n_done, 0);
      chk("b_e5_busy", busy_b, 1);
      tick();
      chk("b_e6_code", code_b, 32'h15);
      chk("b_e6_done", done_b, 1);
      chk("b_e6_busy", busy_b, 0);
      chk("b_e6_locked", locked_b, 1);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_restart_code", code_b, 32'h20);
      chk("b_restart_locked", locked_b, 0);
      chk("b_restart_busy", busy_b, 1);
      chk("b_restart_done", done_b, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
